// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver oversampled at OVERSAMPLE x baud, with a one-byte holding register.
// Define RX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) between the data bits and stop.
module uart_rx #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_ODD = 0
) (
   input  logic                 rxclk,
   input  logic                 reset_n,
   input  logic                 rx_enable,
   input  logic                 rx_in,
   input  logic                 uld_rx_data,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_empty,
   output logic                 rx_frame_err,
   output logic                 rx_over_run,
   output logic                 rx_parity_err,
   output logic [2:0]           o_dbg_state
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
   localparam logic          PAR_SENSE = (PARITY_ODD != 0);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               r_state, w_state_nxt;
   logic                 r_sync1, r_rx_s;
   logic                 r_armed, w_armed_nxt;
   logic [CW-1:0]        r_cnt, w_cnt_nxt;
   logic [BW-1:0]        r_bit_idx, w_bit_nxt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
   logic                 w_done;
   logic                 w_par_err;

`ifdef RX_PARITY_EN
   logic r_par, w_par_nxt;
   assign w_par_err = r_par ^ (^r_shift) ^ PAR_SENSE;
`else
   assign w_par_err = PAR_SENSE & 1'b0;
`endif

   assign o_dbg_state = r_state;

   always_ff @(posedge rxclk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1   <= 1'b1;
         r_rx_s    <= 1'b1;
         r_state   <= S_IDLE;
         r_armed   <= 1'b0;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
`ifdef RX_PARITY_EN
         r_par     <= 1'b0;
`endif
      end else begin
         r_sync1   <= rx_in;
         r_rx_s    <= r_sync1;
         r_state   <= w_state_nxt;
         r_armed   <= w_armed_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_idx <= w_bit_nxt;
         r_shift   <= w_shift_nxt;
`ifdef RX_PARITY_EN
         r_par     <= w_par_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_armed_nxt = r_armed;
      w_cnt_nxt   = r_cnt + CW'(1);
      w_bit_nxt   = r_bit_idx;
      w_shift_nxt = r_shift;
      w_done      = 1'b0;
`ifdef RX_PARITY_EN
      w_par_nxt   = r_par;
`endif
      case (r_state)
         // A line must be seen high before a start is accepted, so a held break never retriggers.
         S_IDLE: begin
            w_cnt_nxt = '0;
            w_bit_nxt = '0;
            if (r_rx_s) begin
               w_armed_nxt = 1'b1;
            end else if (r_armed) begin
               w_armed_nxt = 1'b0;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (r_cnt == CNT_MID) begin
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
               w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_cnt == CNT_END) begin
               w_cnt_nxt   = '0;
               w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
               w_bit_nxt   = r_bit_idx + BW'(1);
               if (r_bit_idx == BIT_LAST) begin
`ifdef RX_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_STOP;
`endif
               end
            end
         end
`ifdef RX_PARITY_EN
         S_PARITY: begin
            if (r_cnt == CNT_END) begin
               w_cnt_nxt   = '0;
               w_par_nxt   = r_rx_s;
               w_state_nxt = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (r_cnt == CNT_END) begin
               w_cnt_nxt   = '0;
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
      if (!rx_enable) begin
         w_state_nxt = S_IDLE;
         w_armed_nxt = 1'b0;
         w_cnt_nxt   = '0;
         w_bit_nxt   = '0;
         w_done      = 1'b0;
      end
   end

   // Holding register handshake: rx_empty==0 offers rx_data; a one-cycle uld_rx_data consumes it.
   always_ff @(posedge rxclk or negedge reset_n) begin
      if (!reset_n) begin
         rx_data       <= '0;
         rx_empty      <= 1'b1;
         rx_frame_err  <= 1'b0;
         rx_over_run   <= 1'b0;
         rx_parity_err <= 1'b0;
      end else begin
         if (uld_rx_data && !rx_empty) begin
            rx_empty    <= 1'b1;
            rx_over_run <= 1'b0;
         end
         if (w_done) begin
            if (rx_empty || uld_rx_data) begin
               rx_data  <= r_shift;
               rx_empty <= 1'b0;
            end else begin
               rx_over_run <= 1'b1;
            end
            rx_frame_err  <= ~r_rx_s;
            rx_parity_err <= w_par_err;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a holding-register model of the receiver.
`timescale 1ns/1ps
module tb_uart_rx;
   localparam int OS = 16;
   localparam int DB = 8;
`ifdef RX_PARITY_EN
   localparam int PBITS = 1;
   localparam logic PODD = 1'b0;
`else
   localparam int PBITS = 0;
`endif
   localparam int NBITS = DB + 2 + PBITS;
   // Edge index of frame completion, counting the first edge that samples the start bit as 0.
   localparam int CMP = 2 + OS / 2 + (DB + 1) * OS + PBITS * OS;

   logic          rxclk = 1'b0;
   logic          reset_n = 1'b0;
   logic          rx_enable = 1'b1;
   logic          rx_in = 1'b1;
   logic          uld_rx_data = 1'b0;
   logic [DB-1:0] rx_data;
   logic          rx_empty, rx_frame_err, rx_over_run, rx_parity_err;
   logic [2:0]    dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   int fall_edge;

   // Scoreboard: exp_q holds the unread byte (at most one); exp_data is the last byte loaded.
   logic [DB-1:0] exp_q[$];
   logic [DB-1:0] exp_data;
   logic          exp_fe, exp_or, exp_pe;

   uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB), .PARITY_ODD(0)) dut (
      .rxclk        (rxclk),
      .reset_n      (reset_n),
      .rx_enable    (rx_enable),
      .rx_in        (rx_in),
      .uld_rx_data  (uld_rx_data),
      .rx_data      (rx_data),
      .rx_empty     (rx_empty),
      .rx_frame_err (rx_frame_err),
      .rx_over_run  (rx_over_run),
      .rx_parity_err(rx_parity_err),
      .o_dbg_state  (dbg_state)
   );

   always #5 rxclk = ~rxclk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
      $fatal(1);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, ".data"},   32'(rx_data),       32'(exp_data));
      check_val({tag, ".empty"},  32'(rx_empty),      32'(exp_q.size() == 0));
      check_val({tag, ".frame"},  32'(rx_frame_err),  32'(exp_fe));
      check_val({tag, ".over"},   32'(rx_over_run),   32'(exp_or));
      check_val({tag, ".parity"}, 32'(rx_parity_err), 32'(exp_pe));
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_data = '0;
      exp_fe   = 1'b0;
      exp_or   = 1'b0;
      exp_pe   = 1'b0;
   endtask

   task automatic model_unload();
      if (exp_q.size() != 0) begin
         exp_q.delete();
         exp_or = 1'b0;
      end
   endtask

   task automatic model_complete(input logic [DB-1:0] d, input logic stop_b, input logic par_flip);
      if (exp_q.size() == 0) begin
         exp_q.push_back(d);
         exp_data = d;
      end else begin
         exp_or = 1'b1;
      end
      exp_fe = ~stop_b;
      exp_pe = (PBITS != 0) ? par_flip : 1'b0;
   endtask

   task automatic line_idle(input logic level, input int n);
      rx_in = level;
      repeat (n) @(negedge rxclk);
   endtask

   task automatic pulse_unload();
      @(negedge rxclk);
      uld_rx_data = 1'b1;
      @(negedge rxclk);
      uld_rx_data = 1'b0;
      model_unload();
   endtask

   // Drives one frame, one bit per OS clocks; uld_at / dis_at are edge indices (-1 = unused).
   // The line is left at the stop-bit level on return.
   task automatic send_frame(input logic [DB-1:0] data, input logic stop_b, input logic par_flip,
                             input int uld_at, input int dis_at);
      logic [NBITS-1:0] bits;
      logic             was_empty;
      bits    = '0;
      for (int i = 0; i < DB; i++) bits[1 + i] = data[i];
`ifdef RX_PARITY_EN
      bits[DB + 1] = (^data) ^ PODD ^ par_flip;
`endif
      bits[NBITS - 1] = stop_b;
      was_empty = (exp_q.size() == 0);
      fall_edge = -1;
      for (int c = 0; c < NBITS * OS; c++) begin
         @(negedge rxclk);
         if (was_empty && fall_edge < 0 && !rx_empty) fall_edge = c - 1;
         rx_in       = bits[c / OS];
         uld_rx_data = (c == uld_at);
         if (c == dis_at) rx_enable = 1'b0;
      end
      @(negedge rxclk);
      uld_rx_data = 1'b0;
      if (dis_at < 0) begin
         if (uld_at >= 0) model_unload();
         model_complete(data, stop_b, par_flip);
      end
   endtask

   initial begin
      model_reset();
      repeat (3) @(negedge rxclk);
      check_outputs("reset");
      reset_n = 1'b1;
      line_idle(1'b1, 4);

      send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
      check_outputs("a5");
      check_val("a5.latency", 32'(fall_edge), 32'(CMP));
      line_idle(1'b1, 4);

      pulse_unload();
      send_frame(8'h3C, 1'b1, 1'b0, -1, -1);
      line_idle(1'b1, 4);
      send_frame(8'hFF, 1'b1, 1'b0, -1, -1);
      check_outputs("overrun");
      pulse_unload();
      check_outputs("overrun_unload");
      line_idle(1'b1, 4);

      line_idle(1'b0, 4);
      line_idle(1'b1, 30);
      check_outputs("glitch");

      send_frame(8'h55, 1'b0, 1'b0, -1, -1);
      line_idle(1'b0, 40 * OS);
      check_outputs("break");
      line_idle(1'b1, 4);

      send_frame(8'h2D, 1'b1, 1'b0, -1, -1);
      line_idle(1'b1, 4);
      send_frame(8'h6B, 1'b1, 1'b0, CMP, -1);
      check_outputs("uld_same_edge");
      line_idle(1'b1, 4);

      pulse_unload();
      send_frame(8'h81, 1'b1, 1'b0, -1, 5 * OS + 8);
      rx_enable = 1'b1;
      check_outputs("enable_drop");
      line_idle(1'b1, 4);
      send_frame(8'h18, 1'b1, 1'b0, -1, -1);
      check_outputs("reenable");
      line_idle(1'b1, 4);

`ifdef RX_PARITY_EN
      pulse_unload();
      send_frame(8'h07, 1'b1, 1'b0, -1, -1);
      check_outputs("parity_good");
      line_idle(1'b1, 4);
      pulse_unload();
      send_frame(8'h07, 1'b1, 1'b1, -1, -1);
      check_outputs("parity_bad");
      line_idle(1'b1, 4);
`endif

      for (int k = 0; k < 24; k++) begin
         logic [DB-1:0] d;
         logic          sb, pf;
         int            mode, ua;
         d    = DB'($urandom_range(0, 255));
         sb   = ($urandom_range(0, 5) != 0);
         pf   = 1'($urandom_range(0, 1));
         mode = $urandom_range(0, 3);
         ua   = -1;
         if (mode == 0) pulse_unload();
         else if (mode == 1) ua = CMP;
         else if (mode == 2) ua = $urandom_range(OS, CMP - 1);
         send_frame(d, sb, pf, ua, -1);
         check_outputs($sformatf("rand%0d", k));
         line_idle(1'b1, $urandom_range(2, 12));
      end

      send_frame(8'hE7, 1'b1, 1'b0, -1, -1);
      line_idle(1'b1, 4);
      send_frame(8'h9A, 1'b0, 1'b0, -1, -1);
      line_idle(1'b1, 4);
      check_outputs("pre_reset");
      rx_in = 1'b0;
      repeat (60) @(negedge rxclk);
      reset_n = 1'b0;
      #1;
      model_reset();
      check_outputs("reset_mid");
      repeat (2) @(negedge rxclk);
      reset_n = 1'b1;
      line_idle(1'b1, 4);
      send_frame(8'hC3, 1'b1, 1'b0, -1, -1);
      check_outputs("after_reset");
      line_idle(1'b1, 4);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
